// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in, serial-out shift register.
package piso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } piso_state_e;

    // Bits needed to hold a bit count from 0 up to and including w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module piso_bit_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;

    // Load has priority over decrement; a decrement at zero is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && !zero_o) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/shift_register_piso.sv
// Parallel-in, serial-out shift register, MSB first, valid/ready load.
// Optional even-parity trailer bit when SHIFT_REGISTER_PISO_PARITY_EN is defined.
module shift_register_piso
    import piso_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             data_out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = cnt_width(WIDTH);

    piso_state_e       state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic              data_out_q, data_out_d;
    logic              out_valid_q, out_valid_d;
    logic              done_q, done_d;
    logic              load_acc;
    logic              shift;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_zero;
    logic              cnt_last;
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
    logic              parity_q, parity_d;
`endif

    piso_bit_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load_acc),
        .load_val_i (CNT_W'(WIDTH)),
        .dec_i      (shift),
        .count_o    (cnt),
        .zero_o     (cnt_zero)
    );

    assign cnt_last = (cnt == CNT_W'(1));

    // State, shift register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            data_out_q  <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    // Next-state decode, load acceptance and shift strobe.
    always_comb begin
        state_d  = state_q;
        load_acc = 1'b0;
        shift    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    load_acc = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (shift_en && !cnt_zero) begin
                    shift = 1'b1;
                    if (cnt_last) begin
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
            end
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
            ST_PARITY: begin
                if (shift_en) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values and registered outputs, decoded from the next state
    // so that the outputs line up with the state they describe.
    always_comb begin
        shreg_d = shreg_q;
        if (load_acc) begin
            shreg_d = load_data;
        end else if (shift) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
        parity_d = load_acc ? ^load_data : parity_q;
`endif
        data_out_d  = 1'b0;
        out_valid_d = 1'b0;
        case (state_d)
            ST_SHIFT: begin
                data_out_d  = shreg_d[WIDTH-1];
                out_valid_d = 1'b1;
            end
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
            ST_PARITY: begin
                data_out_d  = parity_d;
                out_valid_d = 1'b1;
            end
`endif
            default: ;
        endcase
        done_d = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    end

    assign load_ready = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign data_out   = data_out_q;
    assign out_valid  = out_valid_q;
    assign done       = done_q;

endmodule

// File: tb/tb_shift_register_piso.sv
// Self-checking bench for shift_register_piso with a bit-level scoreboard.
module tb_shift_register_piso;

    localparam int WIDTH = 8;
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             shift_en;
    logic             data_out;
    logic             out_valid;
    logic             busy;
    logic             done;

    int   n_checks = 0;
    int   n_pass   = 0;
    bit   exp_q[$];
    logic prev_done = 1'b0;

    shift_register_piso #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .shift_en   (shift_en),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic push_frame(input logic [WIDTH-1:0] w);
        for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(w[i]);
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
        exp_q.push_back(^w);
`endif
    endtask

    // Every consumed bit is popped from the scoreboard; done must be one cycle wide.
    always @(negedge clk) begin
        if (out_valid && shift_en) begin
            if (exp_q.size() == 0) check("unexpected_bit", 32'(out_valid), 32'd0);
            else check("bit", 32'(data_out), 32'(exp_q.pop_front()));
        end
        if (done) check("done_width", 32'(prev_done), 32'd0);
        prev_done = done;
    end

    task automatic wait_ready();
        int n = 0;
        while (!load_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_wait", 32'(load_ready), 32'd1);
    endtask

    // Load one word, strobe shift_en every 'period' cycles, optionally poke
    // load_valid mid-transfer, and check timing up to the done pulse.
    task automatic send_word(input logic [WIDTH-1:0] w, input int period,
                             input bit inject);
        int   cyc, strobes;
        bit   seen, prev_cons, prev_valid;
        logic prev_bit;
        wait_ready();
        load_valid = 1'b1;
        load_data  = w;
        push_frame(w);
        @(posedge clk); #1;
        load_valid = 1'b0;
        load_data  = ~w;
        seen = 0; strobes = 0; prev_cons = 0; prev_valid = 0; prev_bit = 0; cyc = 0;
        while (!seen && cyc < 300) begin
            shift_en = ((cyc % period) == period - 1);
            if (inject && cyc == 5) begin
                load_valid = 1'b1;
                load_data  = 8'h55;
            end else begin
                load_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc == 0) begin
                check("first_valid", 32'(out_valid), 32'd1);
                check("ready_low", 32'(load_ready), 32'd0);
            end
            if (done) begin
                seen = 1;
                check("strobes_at_done", strobes, FRAME);
                check("done_after_last", 32'(prev_cons), 32'd1);
                check("ready_at_done", 32'(load_ready), 32'd1);
                check("valid_at_done", 32'(out_valid), 32'd0);
            end else if (out_valid && prev_valid && !prev_cons) begin
                check("hold", 32'(data_out), 32'(prev_bit));
            end
            prev_cons  = out_valid && shift_en;
            prev_valid = out_valid;
            prev_bit   = data_out;
            if (prev_cons) strobes++;
            @(posedge clk); #1;
            cyc++;
        end
        shift_en   = 1'b0;
        load_valid = 1'b0;
        check("done_seen", 32'(seen), 32'd1);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic back_to_back();
        int  cyc;
        bit  seen;
        wait_ready();
        load_valid = 1'b1;
        load_data  = 8'hFF;
        shift_en   = 1'b1;
        push_frame(8'hFF);
        @(posedge clk); #1;
        load_data = 8'h01;
        seen = 0; cyc = 0;
        while (!seen && cyc < 50) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                check("b2b_gap_valid", 32'(out_valid), 32'd0);
                check("b2b_ready", 32'(load_ready), 32'd1);
                push_frame(8'h01);
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b_done_seen", 32'(seen), 32'd1);
        load_valid = 1'b0;
        @(negedge clk);
        check("b2b_second_valid", 32'(out_valid), 32'd1);
        seen = 0; cyc = 0;
        while (!seen && cyc < 50) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (done) seen = 1;
            cyc++;
        end
        check("b2b_second_done", 32'(seen), 32'd1);
        @(posedge clk); #1;
        shift_en = 1'b0;
        check("b2b_drained", exp_q.size(), 0);
    endtask

    task automatic mid_word_reset();
        wait_ready();
        load_valid = 1'b1;
        load_data  = 8'hF0;
        push_frame(8'hF0);
        @(posedge clk); #1;
        load_valid = 1'b0;
        shift_en   = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(load_ready), 32'd1);
        check("rst_popped", exp_q.size(), FRAME - 3);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_valid", 32'(out_valid), 32'd0);
            check("post_rst_ready", 32'(load_ready), 32'd1);
            @(posedge clk); #1;
        end
        shift_en = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        shift_en   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ready", 32'(load_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_data", 32'(data_out), 32'd0);
        check("reset_done", 32'(done), 32'd0);

        // Release reset with shift_en high on the same edge.
        @(posedge clk); #1;
        reset    = 1'b0;
        shift_en = 1'b1;
        @(negedge clk);
        check("release_busy", 32'(busy), 32'd0);
        check("release_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        shift_en = 1'b0;

        send_word(8'hA5, 1, 1'b0);
        send_word(8'h3C, 3, 1'b0);
        back_to_back();
        mid_word_reset();
        send_word(8'hAA, 2, 1'b1);
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
        send_word(8'h07, 1, 1'b0);
`endif
        for (int i = 0; i < 3; i++) send_word(WIDTH'($urandom), 1 + (i % 2), 1'b0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shift_register_piso.md
# shift_register_piso

Parallel-in, serial-out shift register. It is the transmit-side counterpart of the SIPO shift register: it accepts a WIDTH-bit word through a valid/ready load handshake and emits it MSB-first, one bit per `shift_en` strobe. The MSB-first order means a downstream SIPO shifting in at the LSB reconstructs the original word after WIDTH shifts. It sits between a word-oriented producer and any bit-serial link or SIPO receiver.

## Interface
- WIDTH, 8, data word width; legal range ≥ 2.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_valid  in  1  producer has a word on load_data.
- load_data  in  WIDTH  word to serialize.
- load_ready  out  1  block can accept a word; high only in IDLE.
- shift_en  in  1  bit-rate strobe; the current bit is consumed on a cycle where it is high.
- data_out  out  1  current serial bit.
- out_valid  out  1  data_out carries a valid bit.
- busy  out  1  a word is in flight (state ≠ IDLE).
- done  out  1  one-cycle pulse after the final bit is consumed.

## Operation
- States are IDLE, SHIFT and PARITY. PARITY exists only when the parity macro is defined.
- **IDLE:** load_ready=1. When load_valid is high, the word is accepted: the shift register is loaded with load_data, bit count is set to WIDTH, and the state moves to SHIFT.
- **SHIFT:** data_out = shreg[WIDTH-1] and out_valid=1.
  - On shift_en=1: shift left with 0 fill and decrement the count.
  - When the count reaches 0 after a shift, go to PARITY if enabled, otherwise to IDLE.
  - shift_en=0 holds data_out and the count unchanged. There is no timeout.
- **PARITY:** data_out = parity bit and out_valid=1. On shift_en=1, go to IDLE.
- done=1 for exactly one cycle on the cycle after the final consumed bit (entry into IDLE).
- load_valid is ignored while busy. load_data is sampled only on acceptance and may change afterwards.
- **Reset (async, any state, including mid-word):**
  - state=IDLE, shreg=0, count=0.
  - Outputs: data_out=0, out_valid=0, busy=0, done=0, load_ready=1.
  - The partial word is discarded and nothing is emitted on release.
- The count register is $clog2(WIDTH+1) bits. It never wraps: a decrement from 0 cannot occur.

## Timing
- Load accepted at edge N → first bit (MSB) on data_out with out_valid=1 from cycle N+1.
- With shift_en tied high, WIDTH bits occupy cycles N+1..N+WIDTH.
  - Without parity: done and load_ready are high in cycle N+WIDTH+1.
  - With parity: the parity bit is in N+WIDTH+1, and done is in N+WIDTH+2.
- The next load can be accepted in the done cycle. Back-to-back words therefore have a 1-cycle gap with out_valid=0.
- If shift_en and the reset release edge coincide, nothing happens: the block stays in IDLE.
- All outputs are registered except load_ready and busy, which decode the state register.

## Configuration
- Macro: SHIFT_REGISTER_PISO_PARITY_EN.
- **Defined:** after the last data bit, one extra bit is emitted: even parity (XOR of all WIDTH bits of the accepted word). The parity is computed at load and held in a register.
- **Undefined:** the PARITY state and parity register are absent, and the frame is exactly WIDTH bits.

## Structure
- Shared package piso_pkg holds:
  - the state enum typedef (IDLE, SHIFT, PARITY);
  - a function for the count width, $clog2(WIDTH+1).
- Sub-module piso_bit_counter: loadable down-counter with a zero flag, parameterized by width. The top level holds the FSM, shift register and parity.

## Test plan
- **Basic word:** load 8'hA5 with shift_en=1 continuously → data_out 1,0,1,0,0,1,0,1 in the 8 cycles after acceptance; done pulses once in cycle 9; load_ready=0 throughout the 8 bits.
- **Strobed shifting:** load 8'h3C with shift_en high every 3rd cycle → each bit held stable for 3 cycles; sequence 0,0,1,1,1,1,0,0; done one cycle after the 8th strobe.
- **Back-to-back:** load 8'hFF, then load_valid held with 8'h01 → second word accepted in the done cycle; out_valid=0 for exactly 1 cycle between words; data_out 1×8, then 0×7, 1.
- **Mid-word reset:** after 3 bits of 8'hF0, assert reset asynchronously between edges → data_out, out_valid and busy go to 0 immediately; after release the block is in IDLE with load_ready=1 and no bits emitted.
- **Load ignored while busy:** pulse load_valid with 8'h55 during an 8'hAA transfer → the output stream is exactly the 8'hAA pattern, and 8'h55 is never transmitted.
- **Parity (macro defined):**
  - 8'hA5 → 8 data bits then 0.
  - 8'h07 → 8 data bits then 1.
  - done pulses one cycle after the parity bit.
